icache_nway: RTL and testbench
==============================

# icache_nway

Parametrised N-way set-associative instruction cache between the fetch stage and the AXI read master. It generalises the fixed 2-way/128-set/8-word design to configurable ways, sets and line length. It also adds a ready/valid request handshake, a single-cycle whole-cache invalidate, and a flush that kills an in-flight response. Uncached requests bypass the arrays as single-beat reads.

## Interface
- WAYS, 2: associativity; power of 2, 1..8
- SETS, 128: sets per way; power of 2, 16..512
- LINE_WORDS, 8: 32-bit words per line; power of 2, 2..16
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- cache_ena  in  1  request is cacheable (sampled at accept)
- s_araddr  in  32  fetch address, word aligned
- s_arvalid  in  1  fetch request
- s_arready  out  1  request accepted when s_arvalid&s_arready
- s_rdata  out  32  instruction word
- s_rvalid  out  1  one-cycle data pulse
- flush  in  1  kill pending fetch / block accept
- inv_req  in  1  invalidate all lines (one-cycle pulse)
- m_araddr  out  32  burst start address
- m_arlen  out  8  beats-1: LINE_WORDS-1 when cached, 0 when uncached
- m_arvalid  out  1  address valid, held until m_arready
- m_arready  in  1
- m_rdata  in  32
- m_rvalid  in  1
- m_rlast  in  1
- m_rready  out  1  tied 1

## Operation
- Address split: OFF=log2(LINE_WORDS)+2, IDX=log2(SETS), tag = addr[31:OFF+IDX], index = addr[OFF+IDX-1:OFF], word = addr[OFF-1:2].
- Storage: WAYS×SETS tag array and WAYS×LINE_WORDS×SETS data array with synchronous read. Valid bits are flops. Each set has a log2(WAYS)-bit round-robin victim pointer.
- IDLE: s_arready = !flush & !inv_req. On accept, latch addr and cacheable. Cached requests go to LOOKUP with arrays read at the incoming index. Uncached requests go to MISS_AR.
- inv_req in IDLE clears all valid bits and all victim pointers next edge. inv_req outside IDLE is held pending and applied on the first IDLE cycle, before any accept.
- LOOKUP, hit (exactly one way with valid & tag match): s_rvalid=1, s_rdata = hit way's word, back to IDLE. Hit updates nothing.
- LOOKUP, miss: victim = lowest-numbered invalid way in the set, else the victim pointer. Go to MISS_AR.
- MISS_AR: m_arvalid=1. Address is line-aligned if cached, addr if uncached. Go to REFILL on m_arready.
- REFILL: beat counter 0..m_arlen. Cached beats write the data word [counter] of the victim way. The beat whose counter equals word is captured into a response register. On the m_rvalid&m_rlast beat go to RESP.
- RESP: on cached fills, write tag, set valid, and advance the victim pointer (mod WAYS) only when the victim was the pointer's way. s_rvalid=1 with the captured word unless killed. Back to IDLE.
- Kill: flush asserted in any non-IDLE state sets a kill flag. The bus transaction still completes and the line is still installed, but s_rvalid stays 0 for that request. The flag clears on return to IDLE. Flush in the same cycle as a LOOKUP hit suppresses that s_rvalid.
- m_rlast arriving early ends the refill anyway. The line is installed, and unreceived words hold stale data (bus protocol violation; not checked).

## Timing
- Reset (rst high at edge): state IDLE, all valid 0, victim pointers 0, kill 0, counter 0. m_arvalid=0, s_rvalid=0, s_rdata=0. s_arready=1 the cycle after reset if flush=0 and inv_req=0.
- Hit: accept at edge N, s_rvalid high in cycle N+1. Next accept is possible at edge N+2.
- Miss: m_arvalid rises in cycle N+2 (after LOOKUP). Uncached: in cycle N+1. s_rvalid comes one cycle after the m_rlast beat.
- s_rdata is 0 whenever s_rvalid=0.
- rst mid-refill aborts locally. The external AXI slave must also be reset.

## Test plan
- Cold fetch 0x1000_0004, cached, WAYS=2, LINE_WORDS=8 -> m_araddr=0x1000_0000, m_arlen=7. Beat 1 data 0xA1 returned on s_rvalid one cycle after rlast. Refetch of 0x1000_0008 hits with 1-cycle latency.
- Three tags mapping to set 5, WAYS=2 -> third fill replaces way 0. A fourth new tag replaces way 1. Re-access of the first tag misses.
- Uncached fetch 0x1FC0_0010 -> m_araddr=0x1FC0_0010, m_arlen=0, single beat 0xDEAD returned. A repeat fetch goes to the bus again.
- flush during REFILL -> burst completes, no s_rvalid. A following fetch to the same line hits.
- inv_req after filling 4 lines -> all 4 addresses miss. inv_req during a refill is applied after RESP, and the line just filled also misses.
- Rerun with WAYS=4, SETS=64, LINE_WORDS=4 -> m_arlen=3, index = addr[9:4], and 5 conflicting tags evict way 0 first.

Source files
------------

// File: rtl/icache_nway.sv
// N-way set-associative instruction cache with round-robin replacement,
// whole-cache invalidate, flush-kill of pending responses and uncached bypass.
module icache_nway #(
    parameter int WAYS       = 2,
    parameter int SETS       = 128,
    parameter int LINE_WORDS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cache_ena,
    input  logic [31:0] s_araddr,
    input  logic        s_arvalid,
    output logic        s_arready,
    output logic [31:0] s_rdata,
    output logic        s_rvalid,
    input  logic        flush,
    input  logic        inv_req,
    output logic [31:0] m_araddr,
    output logic [7:0]  m_arlen,
    output logic        m_arvalid,
    input  logic        m_arready,
    input  logic [31:0] m_rdata,
    input  logic        m_rvalid,
    input  logic        m_rlast,
    output logic        m_rready
);
    localparam int OFF = $clog2(LINE_WORDS) + 2;
    localparam int IDX = $clog2(SETS);
    localparam int TW  = 32 - OFF - IDX;
    localparam int WW  = OFF - 2;
    localparam int WB  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int AW  = IDX + WW;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOOKUP  = 3'd1;
    localparam logic [2:0] S_MISS_AR = 3'd2;
    localparam logic [2:0] S_REFILL  = 3'd3;
    localparam logic [2:0] S_RESP    = 3'd4;

    logic [2:0]      state;
    logic [31:0]     addr_q;
    logic            cached_q;
    logic            kill_q;
    logic            inv_pend;
    logic [WW-1:0]   cnt;
    logic [WB-1:0]   victim_q;
    logic [31:0]     resp_q;

    logic [SETS-1:0] valid [WAYS];
    logic [WB-1:0]   vptr [SETS];
    logic [TW-1:0]   tag_mem [WAYS][SETS];
    logic [31:0]     data_mem [WAYS][SETS*LINE_WORDS];
    logic [TW-1:0]   tag_q [WAYS];
    logic [31:0]     data_q [WAYS];

    logic [TW-1:0]   addr_tag;
    logic [IDX-1:0]  addr_idx;
    logic [WW-1:0]   addr_word;
    logic [IDX-1:0]  rd_idx;
    logic [WW-1:0]   rd_word;
    logic [WAYS-1:0] hit_vec;
    logic            one_hit;
    logic [31:0]     hit_data;
    logic [WB-1:0]   victim_sel;
    logic            accept;

    assign addr_tag  = addr_q[31:OFF+IDX];
    assign addr_idx  = addr_q[OFF+IDX-1:OFF];
    assign addr_word = addr_q[OFF-1:2];
    assign rd_idx    = (state == S_IDLE) ? s_araddr[OFF+IDX-1:OFF] : addr_idx;
    assign rd_word   = (state == S_IDLE) ? s_araddr[OFF-1:2] : addr_word;

    assign s_arready = (state == S_IDLE) && !flush && !inv_req && !inv_pend;
    assign accept    = s_arvalid && s_arready;
    assign m_arvalid = (state == S_MISS_AR);
    assign m_araddr  = cached_q ? {addr_q[31:OFF], {OFF{1'b0}}} : addr_q;
    assign m_arlen   = cached_q ? 8'(LINE_WORDS - 1) : 8'd0;
    assign m_rready  = 1'b1;

    always_comb begin
        hit_vec    = '0;
        hit_data   = '0;
        victim_sel = vptr[addr_idx];
        for (int w = 0; w < WAYS; w++) begin
            hit_vec[w] = valid[w][addr_idx] && (tag_q[w] == addr_tag);
            if (hit_vec[w]) hit_data = data_q[w];
        end
        // Fill an empty way before disturbing a live one.
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid[w][addr_idx]) victim_sel = WB'(w);
        end
        one_hit = (hit_vec != '0) &&
                  ((hit_vec & (hit_vec - WAYS'(1))) == '0);
    end

    always_comb begin
        s_rvalid = 1'b0;
        s_rdata  = '0;
        if (state == S_LOOKUP && one_hit && !flush) begin
            s_rvalid = 1'b1;
            s_rdata  = hit_data;
        end else if (state == S_RESP && !kill_q && !flush) begin
            s_rvalid = 1'b1;
            s_rdata  = resp_q;
        end
    end

    always_ff @(posedge clk) begin
        for (int w = 0; w < WAYS; w++) begin
            tag_q[w]  <= tag_mem[w][rd_idx];
            data_q[w] <= data_mem[w][{rd_idx, rd_word}];
            if (state == S_REFILL && m_rvalid && cached_q &&
                victim_q == WB'(w))
                data_mem[w][{addr_idx, cnt}] <= m_rdata;
            if (state == S_RESP && cached_q && victim_q == WB'(w))
                tag_mem[w][addr_idx] <= addr_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            addr_q   <= '0;
            cached_q <= 1'b0;
            kill_q   <= 1'b0;
            inv_pend <= 1'b0;
            cnt      <= '0;
            victim_q <= '0;
            resp_q   <= '0;
            for (int w = 0; w < WAYS; w++) valid[w] <= '0;
            for (int s = 0; s < SETS; s++) vptr[s] <= '0;
        end else begin
            if (flush && state != S_IDLE) kill_q <= 1'b1;
            if (inv_req && state != S_IDLE) inv_pend <= 1'b1;
            unique case (state)
                S_IDLE: begin
                    kill_q <= 1'b0;
                    if (inv_req || inv_pend) begin
                        inv_pend <= 1'b0;
                        for (int w = 0; w < WAYS; w++) valid[w] <= '0;
                        for (int s = 0; s < SETS; s++) vptr[s] <= '0;
                    end else if (accept) begin
                        addr_q   <= s_araddr;
                        cached_q <= cache_ena;
                        state    <= cache_ena ? S_LOOKUP : S_MISS_AR;
                    end
                end
                S_LOOKUP: begin
                    if (one_hit) begin
                        state <= S_IDLE;
                    end else begin
                        victim_q <= victim_sel;
                        state    <= S_MISS_AR;
                    end
                end
                S_MISS_AR: begin
                    cnt <= '0;
                    if (m_arready) state <= S_REFILL;
                end
                S_REFILL: begin
                    if (m_rvalid) begin
                        if (!cached_q || cnt == addr_word) resp_q <= m_rdata;
                        cnt <= cnt + WW'(1);
                        if (m_rlast) begin
                            cnt   <= '0;
                            state <= S_RESP;
                        end
                    end
                end
                S_RESP: begin
                    if (cached_q) begin
                        valid[victim_q][addr_idx] <= 1'b1;
                        if (WAYS > 1 && victim_q == vptr[addr_idx])
                            vptr[addr_idx] <= vptr[addr_idx] + WB'(1);
                    end
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_icache_nway.sv
// Bench for icache_nway: two configurations driven side by side, with a
// set/way occupancy model and a memory-image AXI slave inside the bench.
module tb_icache_nway;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [1:0]  cache_ena, s_arvalid, s_arready, s_rvalid, flush, inv_req;
    logic [1:0]  m_arvalid, m_arready, m_rvalid, m_rlast, m_rready;
    logic [31:0] s_araddr [2];
    logic [31:0] s_rdata [2];
    logic [31:0] m_araddr [2];
    logic [31:0] m_rdata [2];
    logic [7:0]  m_arlen [2];

    icache_nway #(.WAYS(2), .SETS(128), .LINE_WORDS(8)) u0 (
        .clk(clk), .rst(rst), .cache_ena(cache_ena[0]),
        .s_araddr(s_araddr[0]), .s_arvalid(s_arvalid[0]),
        .s_arready(s_arready[0]), .s_rdata(s_rdata[0]),
        .s_rvalid(s_rvalid[0]), .flush(flush[0]), .inv_req(inv_req[0]),
        .m_araddr(m_araddr[0]), .m_arlen(m_arlen[0]),
        .m_arvalid(m_arvalid[0]), .m_arready(m_arready[0]),
        .m_rdata(m_rdata[0]), .m_rvalid(m_rvalid[0]),
        .m_rlast(m_rlast[0]), .m_rready(m_rready[0])
    );

    icache_nway #(.WAYS(4), .SETS(64), .LINE_WORDS(4)) u1 (
        .clk(clk), .rst(rst), .cache_ena(cache_ena[1]),
        .s_araddr(s_araddr[1]), .s_arvalid(s_arvalid[1]),
        .s_arready(s_arready[1]), .s_rdata(s_rdata[1]),
        .s_rvalid(s_rvalid[1]), .flush(flush[1]), .inv_req(inv_req[1]),
        .m_araddr(m_araddr[1]), .m_arlen(m_arlen[1]),
        .m_arvalid(m_arvalid[1]), .m_arready(m_arready[1]),
        .m_rdata(m_rdata[1]), .m_rvalid(m_rvalid[1]),
        .m_rlast(m_rlast[1]), .m_rready(m_rready[1])
    );

    int nvec = 0;
    int nfail = 0;
    int unsigned ways_p [2] = '{2, 4};
    int unsigned sets_p [2] = '{128, 64};
    int unsigned lw_p [2]   = '{8, 4};

    // Occupancy model: which tag sits in which way of each set.
    int unsigned mtag [2][512][8];
    bit          mval [2][512][8];
    int unsigned mptr [2][512];

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ 32'hC3A5_0F96 ^ {a[15:0], a[31:16]};
    endfunction

    function automatic int unsigned set_of(input int d, input logic [31:0] a);
        return (a / (lw_p[d] * 4)) % sets_p[d];
    endfunction

    function automatic int unsigned tag_of(input int d, input logic [31:0] a);
        return a / (lw_p[d] * 4 * sets_p[d]);
    endfunction

    function automatic bit m_hit(input int d, input logic [31:0] a);
        int unsigned s = set_of(d, a);
        for (int w = 0; w < int'(ways_p[d]); w++)
            if (mval[d][s][w] && mtag[d][s][w] == tag_of(d, a)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void m_fill(input int d, input logic [31:0] a);
        int unsigned s = set_of(d, a);
        int v = -1;
        for (int w = 0; w < int'(ways_p[d]); w++)
            if (!mval[d][s][w] && v < 0) v = w;
        if (v < 0) v = int'(mptr[d][s]);
        if (v == int'(mptr[d][s])) mptr[d][s] = (mptr[d][s] + 1) % ways_p[d];
        mtag[d][s][v] = tag_of(d, a);
        mval[d][s][v] = 1'b1;
    endfunction

    function automatic void m_inv(input int d);
        for (int s = 0; s < 512; s++) begin
            mptr[d][s] = 0;
            for (int w = 0; w < 8; w++) mval[d][s][w] = 1'b0;
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic fetch(input int d, input logic [31:0] a, input bit c,
                         input int kill_beat, input bit fl_lk,
                         input int inv_beat);
        bit hit, killed;
        int unsigned len;
        logic [31:0] base;
        int dly;
        hit    = c && m_hit(d, a);
        killed = fl_lk || kill_beat >= 0;
        len    = c ? lw_p[d] - 1 : 0;
        base   = c ? a - a % (lw_p[d] * 4) : a;
        @(negedge clk);
        s_araddr[d] = a; cache_ena[d] = c; s_arvalid[d] = 1'b1;
        #1 chk("arready", 32'(s_arready[d]), 32'd1);
        @(negedge clk);
        s_arvalid[d] = 1'b0; flush[d] = fl_lk;
        #1;
        if (hit) begin
            chk("hit_rvalid", 32'(s_rvalid[d]), 32'(!fl_lk));
            chk("hit_rdata", s_rdata[d], fl_lk ? 32'd0 : memf(a));
            chk("hit_arvalid", 32'(m_arvalid[d]), 32'd0);
            @(posedge clk);
            #1 flush[d] = 1'b0;
            return;
        end
        chk("miss_rvalid", 32'(s_rvalid[d]), 32'd0);
        if (c) begin
            chk("lookup_arvalid", 32'(m_arvalid[d]), 32'd0);
            @(negedge clk);
            #1;
        end
        flush[d] = 1'b0;
        dly = $urandom_range(0, 2);
        for (int k = 0; k < dly; k++) begin
            chk("ar_hold", 32'(m_arvalid[d]), 32'd1);
            @(negedge clk);
            #1;
        end
        chk("arvalid", 32'(m_arvalid[d]), 32'd1);
        chk("araddr", m_araddr[d], base);
        chk("arlen", 32'(m_arlen[d]), 32'(len));
        m_arready[d] = 1'b1;
        @(negedge clk);
        m_arready[d] = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            m_rvalid[d] = 1'b1;
            m_rdata[d]  = memf(base + 32'(4 * i));
            m_rlast[d]  = (i == int'(len));
            flush[d]    = (i == kill_beat);
            inv_req[d]  = (i == inv_beat);
            @(negedge clk);
        end
        m_rvalid[d] = 1'b0; m_rlast[d] = 1'b0;
        flush[d] = 1'b0; inv_req[d] = 1'b0;
        #1;
        chk("resp_rvalid", 32'(s_rvalid[d]), 32'(!killed));
        chk("resp_rdata", s_rdata[d], killed ? 32'd0 : memf(a));
        if (c) m_fill(d, a);
        if (inv_beat >= 0) begin
            m_inv(d);
            @(negedge clk);
            #1 chk("inv_pend_arready", 32'(s_arready[d]), 32'd0);
        end
    endtask

    task automatic inv_pulse(input int d);
        @(negedge clk);
        inv_req[d] = 1'b1;
        #1 chk("inv_arready", 32'(s_arready[d]), 32'd0);
        @(negedge clk);
        inv_req[d] = 1'b0;
        m_inv(d);
    endtask

    task automatic rand_run(input int d, input int n);
        logic [31:0] a;
        bit c, fl;
        int kb;
        for (int i = 0; i < n; i++) begin
            a = 32'h6000_0000
              + 32'($urandom_range(0, 5) * lw_p[d] * 4 * sets_p[d])
              + 32'($urandom_range(0, 3) * lw_p[d] * 4)
              + 32'($urandom_range(0, lw_p[d] - 1) * 4);
            c  = ($urandom_range(0, 9) != 0);
            fl = c && ($urandom_range(0, 9) == 0);
            kb = (!fl && $urandom_range(0, 7) == 0)
               ? int'($urandom_range(0, c ? lw_p[d] - 1 : 0)) : -1;
            if ($urandom_range(0, 14) == 0) inv_pulse(d);
            fetch(d, a, c, kb, fl, -1);
        end
    endtask

    initial begin
        rst = 1'b1;
        cache_ena = '0; s_arvalid = '0; flush = '0; inv_req = '0;
        m_arready = '0; m_rvalid = '0; m_rlast = '0;
        for (int d = 0; d < 2; d++) begin
            s_araddr[d] = '0; m_rdata[d] = '0;
            m_inv(d);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("rst_arready", 32'(s_arready[d]), 32'd1);
            chk("rst_rvalid", 32'(s_rvalid[d]), 32'd0);
            chk("rst_rdata", s_rdata[d], 32'd0);
            chk("rst_arvalid", 32'(m_arvalid[d]), 32'd0);
            chk("rst_rready", 32'(m_rready[d]), 32'd1);
        end

        fetch(0, 32'h1000_0004, 1'b1, -1, 1'b0, -1);
        fetch(0, 32'h1000_0008, 1'b1, -1, 1'b0, -1);
        for (int k = 0; k < 4; k++)
            fetch(0, 32'h2000_00A0 + 32'(k * 32'h1000), 1'b1, -1, 1'b0, -1);
        fetch(0, 32'h2000_00A0, 1'b1, -1, 1'b0, -1);
        fetch(0, 32'h2000_30A4, 1'b1, -1, 1'b0, -1);
        fetch(0, 32'h1FC0_0010, 1'b0, -1, 1'b0, -1);
        fetch(0, 32'h1FC0_0010, 1'b0, -1, 1'b0, -1);
        fetch(0, 32'h3000_0000, 1'b1, 3, 1'b0, -1);
        fetch(0, 32'h3000_0010, 1'b1, -1, 1'b0, -1);
        fetch(0, 32'h3000_0014, 1'b1, -1, 1'b1, -1);
        fetch(0, 32'h3000_0018, 1'b1, -1, 1'b0, -1);
        for (int k = 0; k < 4; k++)
            fetch(0, 32'h4000_0000 + 32'(k * 32), 1'b1, -1, 1'b0, -1);
        inv_pulse(0);
        for (int k = 0; k < 4; k++)
            fetch(0, 32'h4000_0000 + 32'(k * 32), 1'b1, -1, 1'b0, -1);
        fetch(0, 32'h5000_0000, 1'b1, -1, 1'b0, 2);
        fetch(0, 32'h5000_0000, 1'b1, -1, 1'b0, -1);
        rand_run(0, 50);

        for (int k = 0; k < 5; k++)
            fetch(1, 32'h7000_0030 + 32'(k * 1024), 1'b1, -1, 1'b0, -1);
        fetch(1, 32'h7000_0030, 1'b1, -1, 1'b0, -1);
        fetch(1, 32'h7000_0838, 1'b1, -1, 1'b0, -1);
        fetch(1, 32'h7000_0D3C, 1'b1, -1, 1'b0, -1);
        fetch(1, 32'h1FC0_0010, 1'b0, 0, 1'b0, -1);
        rand_run(1, 50);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
